// File: rtl/bcd_countdown_timer_if.sv
// Control and display bundle for the MM:SS BCD countdown timer.
// The master drives the controls; the slave (timer) drives the digits and status.
interface bcd_countdown_timer_if;
  logic       tick;
  logic       start;
  logic       stop;
  logic       ack;
  logic       load;
  logic [3:0] setMin1;
  logic [3:0] setMin0;
  logic [3:0] setSec1;
  logic [3:0] setSec0;
  logic [3:0] min1;
  logic [3:0] min0;
  logic [3:0] sec1;
  logic [3:0] sec0;
  logic       running;
  logic       alarm;
  logic       loadErr;

  modport master (
    output tick, start, stop, ack, load,
    output setMin1, setMin0, setSec1, setSec0,
    input  min1, min0, sec1, sec0,
    input  running, alarm, loadErr
  );

  modport slave (
    input  tick, start, stop, ack, load,
    input  setMin1, setMin0, setSec1, setSec0,
    output min1, min0, sec1, sec0,
    output running, alarm, loadErr
  );
endinterface

// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown timer with a sticky 00:00 alarm.
// Decrements once per tick in RUN; ack reloads the preset digits.
module bcd_countdown_timer #(
  parameter logic [3:0] PRESET_MIN1 = 4'd3,
  parameter logic [3:0] PRESET_MIN0 = 4'd0,
  parameter logic [3:0] PRESET_SEC1 = 4'd0,
  parameter logic [3:0] PRESET_SEC0 = 4'd0,
  parameter bit         AUTO_RELOAD = 1'b1
) (
  input logic clk,
  input logic reset,
  bcd_countdown_timer_if.slave tmr
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] ALARM = 2'd2;

  logic [1:0] state;
  logic [3:0] m1, m0, s1, s0;
  logic       err;

  logic [3:0] d_m1, d_m0, d_s1, d_s0;
  logic       s0_z, s1_z, m0_z, m1_z;
  logic       cur_zero, dec_zero, set_ok;

  assign s0_z     = (s0 == 4'd0);
  assign s1_z     = (s1 == 4'd0);
  assign m0_z     = (m0 == 4'd0);
  assign m1_z     = (m1 == 4'd0);
  assign cur_zero = s0_z && s1_z && m0_z && m1_z;

  assign set_ok = (tmr.setMin1 <= 4'd9) && (tmr.setMin0 <= 4'd9) &&
                  (tmr.setSec1 <= 4'd5) && (tmr.setSec0 <= 4'd9);

  // Borrow chain; saturates at 00:00 so an all-zero reload cannot wrap.
  always_comb begin
    d_m1 = m1;
    d_m0 = m0;
    d_s1 = s1;
    d_s0 = s0;
    if (!cur_zero) begin
      d_s0 = s0_z ? 4'd9 : s0 - 4'd1;
      if (s0_z) begin
        d_s1 = s1_z ? 4'd5 : s1 - 4'd1;
        if (s1_z) begin
          d_m0 = m0_z ? 4'd9 : m0 - 4'd1;
          if (m0_z)
            d_m1 = m1 - 4'd1;
        end
      end
    end
  end

  assign dec_zero = (d_m1 == 4'd0) && (d_m0 == 4'd0) &&
                    (d_s1 == 4'd0) && (d_s0 == 4'd0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      m1    <= PRESET_MIN1;
      m0    <= PRESET_MIN0;
      s1    <= PRESET_SEC1;
      s0    <= PRESET_SEC0;
      err   <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (tmr.stop) begin
            state <= IDLE;
          end else if (tmr.load) begin
            if (set_ok) begin
              m1 <= tmr.setMin1;
              m0 <= tmr.setMin0;
              s1 <= tmr.setSec1;
              s0 <= tmr.setSec0;
            end else begin
              err <= 1'b1;
            end
          end else if (tmr.start) begin
            state <= cur_zero ? ALARM : RUN;
          end
        end
        RUN: begin
          if (tmr.stop) begin
            state <= IDLE;
          end else if (tmr.tick) begin
            m1 <= d_m1;
            m0 <= d_m0;
            s1 <= d_s1;
            s0 <= d_s0;
            if (dec_zero)
              state <= ALARM;
          end
        end
        ALARM: begin
          if (tmr.ack) begin
            m1    <= PRESET_MIN1;
            m0    <= PRESET_MIN0;
            s1    <= PRESET_SEC1;
            s0    <= PRESET_SEC0;
            state <= AUTO_RELOAD ? RUN : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tmr.min1    = m1;
  assign tmr.min0    = m0;
  assign tmr.sec1    = s1;
  assign tmr.sec0    = s0;
  assign tmr.running = (state == RUN);
  assign tmr.alarm   = (state == ALARM);
  assign tmr.loadErr = err;

endmodule
